// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the round-robin word-mux arbiter.
// Contents: requester count, data width, select width, default stall
// limit, and the FSM state encoding.
package mux_arb_pkg;

    localparam int N_REQ           = 16;
    localparam int DW              = 32;
    localparam int SELW            = 4;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search.
// Ports:
//   req   in  [N_REQ-1:0]  request vector
//   ptr   in  [SELW-1:0]   highest-priority index for this search
//   idx   out [SELW-1:0]   first requester at or after ptr (wrapping)
//   found out              any request present
// The request vector is rotated so that ptr lands on bit 0, a fixed
// lowest-index priority search runs on the rotated vector, and ptr is
// added back to recover the absolute index.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SELW-1:0]  ptr,
    output logic [SELW-1:0]  idx,
    output logic             found
);

    logic [N_REQ-1:0] rot;
    logic [SELW-1:0]  pos;

    always_comb begin
        // SELW-bit index add wraps modulo N_REQ for free.
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[SELW'(i) + ptr];
        end
    end

    always_comb begin
        pos = '0;
        // Descending scan so the lowest set bit is the last assignment.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = SELW'(i);
            end
        end
    end

    assign idx   = pos + ptr;
    assign found = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sharing one 32-bit output channel
// among 16 requesters, with a registered valid/ready output stage and a
// one-cycle grant acknowledge per accepted word.
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   req          in   [15:0] per-source request, held until gnt
//   in_data      in   [511:0] source words, source i at [i*32 +: 32]
//   sel          out  [3:0] current/last winner (word mux select)
//   out_data     out  [31:0] captured word
//   out_valid    out  out_data valid
//   out_ready    in   downstream accepts out_data
//   gnt          out  [15:0] one-hot acknowledge, one cycle
//   busy         out  high while in XFER
//   err_timeout  out  one-cycle stall-abort pulse
// Optional feature: define MUX_ARB_TIMEOUT_EN to abort a transfer that
// is stalled for TIMEOUT cycles; otherwise err_timeout is tied low.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no word held; arbitrate among req starting at ptr
// XFER  | word captured and offered downstream; wait for out_ready
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] in_data,
   output logic [SELW-1:0]     sel,
   output logic [DW-1:0]       out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N_REQ-1:0]    gnt,
   output logic                busy,
   output logic                err_timeout
);

   state_t           state_q, state_d;
   logic [SELW-1:0]  ptr_q, ptr_d;
   logic [SELW-1:0]  sel_q, sel_d;
   logic [DW-1:0]    out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;

   logic [SELW-1:0]  pick_idx;
   logic             pick_found;
   logic [DW-1:0]    words [N_REQ];

   rr_pick u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         words[i] = in_data[i*DW +: DW];
      end
   end

`ifdef MUX_ARB_TIMEOUT_EN
   localparam logic [7:0] STALL_LIM = 8'(TIMEOUT);
   logic [7:0] stall_cnt_q, stall_cnt_d;
   logic       err_timeout_q, err_timeout_d;
`endif

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      gnt_d       = '0;
`ifdef MUX_ARB_TIMEOUT_EN
      stall_cnt_d   = stall_cnt_q;
      err_timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            out_valid_d = 1'b0;
            if (pick_found) begin
               sel_d       = pick_idx;
               out_data_d  = words[pick_idx];
               out_valid_d = 1'b1;
               state_d     = XFER;
`ifdef MUX_ARB_TIMEOUT_EN
               stall_cnt_d = '0;
`endif
            end
         end
         XFER: begin
            if (out_ready) begin
               gnt_d       = N_REQ'(1) << sel_q;
               out_valid_d = 1'b0;
               ptr_d       = sel_q + SELW'(1);
               state_d     = IDLE;
            end
`ifdef MUX_ARB_TIMEOUT_EN
            else if (stall_cnt_q == STALL_LIM) begin
               out_valid_d   = 1'b0;
               err_timeout_d = 1'b1;
               ptr_d         = sel_q + SELW'(1);
               state_d       = IDLE;
            end else begin
               stall_cnt_d = stall_cnt_q + 8'd1;
            end
`endif
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         sel_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         gnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         gnt_q       <= gnt_d;
      end
   end

`ifdef MUX_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q   <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         stall_cnt_q   <= stall_cnt_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign err_timeout = err_timeout_q;
`else
   assign err_timeout = 1'b0;
`endif

   assign sel       = sel_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign gnt       = gnt_q;
   assign busy      = (state_q == XFER);

endmodule
